// File: rtl/fire2_3_expand1_sched_pkg.sv
// rtl/fire2_3_expand1_sched_pkg.sv - shared types and default sizes for the fire2/fire3 expand-1x1 sequencer
package fire_expand_pkg;

    localparam int WOUT_DEFAULT = 64;
    localparam int CHIN_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC2  = 3'd1,
        WR2   = 3'd2,
        WAIT2 = 3'd3,
        ACC3  = 3'd4,
        WR3   = 3'd5,
        WAIT3 = 3'd6
    } sched_state_t;

endpackage

// File: rtl/fire2_3_expand1_sched_if.sv
// rtl/fire2_3_expand1_sched_if.sv - control/status bundle of the expand-1x1 sequencer (ifm_valid only with FIRE_EXPAND1_STALL_EN)
interface fire2_3_expand1_sched_if #(
    parameter int AW = 4,
    parameter int PW = 12
);
    logic          start;
    logic          ram_feedback_2;
    logic          ram_feedback_3;
`ifdef FIRE_EXPAND1_STALL_EN
    logic          ifm_valid;
`endif
    logic          fire2_expand_1_en;
    logic          fire3_expand_1_en;
    logic [AW-1:0] weight_rom_address;
    logic          mac_en;
    logic          mac_clr;
    logic          ofm_sample;
    logic [PW-1:0] pixel_index;
    logic          fire2_expand_1_finish;
    logic          fire3_expand_1_finish;
    logic          busy;
    logic          done;

    modport master (
`ifdef FIRE_EXPAND1_STALL_EN
        output ifm_valid,
`endif
        output start, ram_feedback_2, ram_feedback_3,
        input  fire2_expand_1_en, fire3_expand_1_en, weight_rom_address,
        input  mac_en, mac_clr, ofm_sample, pixel_index,
        input  fire2_expand_1_finish, fire3_expand_1_finish, busy, done
    );

    modport slave (
`ifdef FIRE_EXPAND1_STALL_EN
        input  ifm_valid,
`endif
        input  start, ram_feedback_2, ram_feedback_3,
        output fire2_expand_1_en, fire3_expand_1_en, weight_rom_address,
        output mac_en, mac_clr, ofm_sample, pixel_index,
        output fire2_expand_1_finish, fire3_expand_1_finish, busy, done
    );

endinterface

// File: rtl/fire2_3_expand1_sched_counter.sv
// rtl/fire2_3_expand1_sched_counter.sv - two-level channel (k) / pixel counter for the expand-1x1 sequencer
module fire_expand1_seq_counter #(
    parameter int WOUT = 64,
    parameter int CHIN = 16,
    parameter int AW   = $clog2(CHIN),
    parameter int PW   = $clog2(WOUT*WOUT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_k,
    input  logic          clr_k,
    input  logic          inc_pixel,
    input  logic          clr_pixel,
    output logic [AW-1:0] k,
    output logic [PW-1:0] pixel,
    output logic          wrap_k,
    output logic          last_pixel
);

    // Neither counter rolls over on its own; the sequencer clears them explicitly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k     <= '0;
            pixel <= '0;
        end else begin
            if (clr_k)
                k <= '0;
            else if (inc_k)
                k <= k + AW'(1);

            if (clr_pixel)
                pixel <= '0;
            else if (inc_pixel)
                pixel <= pixel + PW'(1);
        end
    end

    assign wrap_k     = (k == AW'(CHIN - 1));
    assign last_pixel = (pixel == PW'(WOUT*WOUT - 1));

endmodule

// File: rtl/fire2_3_expand1_sched.sv
// rtl/fire2_3_expand1_sched.sv - fire2 then fire3 expand-1x1 MAC sequencer; FIRE_EXPAND1_STALL_EN adds ifm_valid stalling
module fire2_3_expand1_sched
    import fire_expand_pkg::*;
#(
    parameter int WOUT = WOUT_DEFAULT,
    parameter int CHIN = CHIN_DEFAULT,
    parameter int AW   = $clog2(CHIN),
    parameter int PW   = $clog2(WOUT*WOUT)
) (
    input  logic                  clk,
    input  logic                  rst,
    fire2_3_expand1_sched_if.slave bus
);

    sched_state_t  state;
    logic          fb2_latch;
    logic          fb3_latch;
    logic          in_valid;
    logic          acc;
    logic          wr;
    logic [AW-1:0] k;
    logic [PW-1:0] pixel;
    logic          wrap_k;
    logic          last_pixel;

`ifdef FIRE_EXPAND1_STALL_EN
    assign in_valid = bus.ifm_valid;
`else
    assign in_valid = 1'b1;
`endif

    assign acc = (state == ACC2) || (state == ACC3);
    assign wr  = (state == WR2)  || (state == WR3);

    fire_expand1_seq_counter #(
        .WOUT (WOUT),
        .CHIN (CHIN),
        .AW   (AW),
        .PW   (PW)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .inc_k      (acc && in_valid && !wrap_k),
        .clr_k      (wr),
        .inc_pixel  (wr && !last_pixel),
        .clr_pixel  (wr && last_pixel),
        .k          (k),
        .pixel      (pixel),
        .wrap_k     (wrap_k),
        .last_pixel (last_pixel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fb2_latch <= 1'b0;
            fb3_latch <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (bus.start) state <= ACC2;
                ACC2:    if (in_valid && wrap_k) state <= WR2;
                WR2:     state <= last_pixel ? WAIT2 : ACC2;
                WAIT2:   if (fb2_latch) state <= ACC3;
                ACC3:    if (in_valid && wrap_k) state <= WR3;
                WR3:     state <= last_pixel ? WAIT3 : ACC3;
                WAIT3:   if (fb3_latch) state <= IDLE;
                default: state <= IDLE;
            endcase

            // Feedback may arrive early; it is held until its own WAIT state consumes it.
            if (state != IDLE) begin
                if (state == WAIT2 && fb2_latch)
                    fb2_latch <= 1'b0;
                else if (bus.ram_feedback_2)
                    fb2_latch <= 1'b1;

                if (state == WAIT3 && fb3_latch)
                    fb3_latch <= 1'b0;
                else if (bus.ram_feedback_3)
                    fb3_latch <= 1'b1;
            end
        end
    end

    assign bus.fire2_expand_1_en     = (state == ACC2) || (state == WR2) || (state == WAIT2);
    assign bus.fire3_expand_1_en     = (state == ACC3) || (state == WR3) || (state == WAIT3);
    assign bus.weight_rom_address    = acc ? k : '0;
    assign bus.mac_en                = acc && in_valid;
    assign bus.mac_clr               = wr;
    assign bus.ofm_sample            = wr;
    assign bus.pixel_index           = pixel;
    assign bus.fire2_expand_1_finish = (state == WAIT2) && !fb2_latch;
    assign bus.fire3_expand_1_finish = (state == WAIT3) && !fb3_latch;
    assign bus.busy                  = (state != IDLE);
    assign bus.done                  = (state == WAIT3) && fb3_latch;

endmodule
